// File: rtl/iis_controller.sv
// rtl/iis_controller.sv - full-duplex I2S port with master/slave clocking and 8-entry sample FIFOs

module iis_fifo (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        push,
    input  logic        pop,
    input  logic [2:0]  depth,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty
);
    logic [31:0] mem [8];
    logic [2:0]  wptr;
    logic [2:0]  rptr;
    logic        do_push;
    logic        do_pop;
    logic [3:0]  depth_eff;

    assign depth_eff = (depth == 3'd0) ? 4'd8 : {1'b0, depth};
    assign do_push   = push && (count != 4'd8);
    assign do_pop    = pop && (count != 4'd0);
    assign empty     = (count == 4'd0);
    assign full      = (count >= depth_eff);
    assign rdata     = empty ? 32'd0 : mem[rptr];

    // Storage array; unread slots need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping; clear wins over same-cycle push/pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= 3'd0;
            rptr  <= 3'd0;
            count <= 4'd0;
        end else if (clear) begin
            wptr  <= 3'd0;
            rptr  <= 3'd0;
            count <= 4'd0;
        end else begin
            if (do_push) wptr <= wptr + 3'd1;
            if (do_pop)  rptr <= rptr + 3'd1;
            if (do_push && !do_pop)      count <= count + 4'd1;
            else if (do_pop && !do_push) count <= count - 4'd1;
        end
    end
endmodule

module iis_controller (
    input  logic        clk,
    input  logic        rstn,
    input  logic        test_se,
    input  logic        enable,
    input  logic        enable_master,
    input  logic [31:0] bdiv,
    input  logic [31:0] lrbdiv,
    input  logic [3:0]  msb_delay_bits,
    input  logic        bclk_i,
    input  logic        lrclk_i,
    output logic        bclk_o,
    output logic        lrclk_o,
    input  logic        enable_tx,
    input  logic        tx_bpol,
    input  logic        tx_lrpol,
    input  logic [31:0] tx_data_l,
    input  logic [31:0] tx_data_r,
    input  logic        tx_data_fill,
    input  logic        tx_data_clear,
    input  logic [2:0]  tx_data_depth,
    output logic        tx_data_l_full,
    output logic        tx_data_l_empty,
    output logic        tx_data_r_full,
    output logic        tx_data_r_empty,
    output logic [3:0]  tx_data_l_count,
    output logic [3:0]  tx_data_r_count,
    output logic        tx,
    input  logic        enable_rx,
    input  logic        rx_bpol,
    input  logic        rx_lrpol,
    input  logic        rx,
    output logic [31:0] rx_data_l,
    output logic [31:0] rx_data_r,
    input  logic        rx_data_drain,
    input  logic        rx_data_clear,
    input  logic [2:0]  rx_data_depth,
    output logic        rx_data_l_full,
    output logic        rx_data_l_empty,
    output logic        rx_data_r_full,
    output logic        rx_data_r_empty,
    output logic [3:0]  rx_data_l_count,
    output logic [3:0]  rx_data_r_count
);
    logic unused_test_se;
    assign unused_test_se = test_se;

    // Bit k of a slot lives in bclk period delay+k; anything outside 0..31 is silence
    function automatic logic slot_bit(input logic [31:0] w, input logic [5:0] p, input logic [3:0] d);
        logic [6:0] k;
        logic       r;
        k = {1'b0, p} - {3'b000, d};
        r = 1'b0;
        if (({1'b0, p} >= {3'b000, d}) && (k < 7'd32)) r = w[5'd31 - k[4:0]];
        return r;
    endfunction

    function automatic logic [31:0] slot_set(input logic [31:0] w, input logic [5:0] p, input logic [3:0] d, input logic b);
        logic [6:0]  k;
        logic [31:0] r;
        k = {1'b0, p} - {3'b000, d};
        r = w;
        if (({1'b0, p} >= {3'b000, d}) && (k < 7'd32)) r[5'd31 - k[4:0]] = b;
        return r;
    endfunction

    logic        run_m, run_s;
    logic [31:0] bdiv_eff, half, lrbdiv_eff;
    logic [31:0] m_cnt, m_bcnt;
    logic        m_lr, m_rise, m_fall, m_tog;
    logic [2:0]  sb, sl;
    logic [1:0]  sr;
    logic        b_rise, b_fall, lr_rise, lr_fall, rx_bit;

    assign run_m      = enable && enable_master;
    assign run_s      = enable && !enable_master;
    assign bdiv_eff   = (bdiv < 32'd2) ? 32'd2 : bdiv;
    assign half       = bdiv_eff >> 1;
    assign lrbdiv_eff = (lrbdiv == 32'd0) ? 32'd1 : lrbdiv;

    assign m_rise  = run_m && (m_cnt == half - 32'd1);
    assign m_fall  = run_m && (m_cnt >= bdiv_eff - 32'd1);
    assign m_tog   = m_fall && (m_bcnt >= lrbdiv_eff - 32'd1);
    assign bclk_o  = run_m && (m_cnt >= half);
    assign lrclk_o = run_m && m_lr;

    // Master clock divider: bclk from the cycle counter, lrclk flips on a bclk falling edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt  <= 32'd0;
            m_bcnt <= 32'd0;
            m_lr   <= 1'b0;
        end else if (!run_m) begin
            m_cnt  <= 32'd0;
            m_bcnt <= 32'd0;
            m_lr   <= 1'b0;
        end else begin
            m_cnt <= m_fall ? 32'd0 : m_cnt + 32'd1;
            if (m_fall) m_bcnt <= m_tog ? 32'd0 : m_bcnt + 32'd1;
            if (m_tog)  m_lr <= !m_lr;
        end
    end

    // Slave pin synchronizers; third bclk/lrclk stage is the edge-detect history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb <= 3'd0;
            sl <= 3'd0;
            sr <= 2'd0;
        end else begin
            sb <= {sb[1:0], bclk_i};
            sl <= {sl[1:0], lrclk_i};
            sr <= {sr[0], rx};
        end
    end

    assign b_rise  = m_rise | (run_s && sb[1] && !sb[2]);
    assign b_fall  = m_fall | (run_s && !sb[1] && sb[2]);
    assign lr_rise = (m_tog && !m_lr) | (run_s && sl[1] && !sl[2]);
    assign lr_fall = (m_tog && m_lr) | (run_s && !sl[1] && sl[2]);
    assign rx_bit  = enable_master ? rx : sr[1];

    // Transmit side
    logic        tx_active, tx_ev, tx_left, tx_right, tx_pop, tx_fill_ok;
    logic        tx_started, tx_in_right, tx_q;
    logic [5:0]  tx_pidx;
    logic [31:0] tx_word_l, tx_word_r, tl_head, tr_head, new_l, new_r;

    assign tx_active  = enable && enable_tx;
    assign tx_ev      = tx_bpol ? b_rise : b_fall;
    assign tx_left    = tx_lrpol ? lr_rise : lr_fall;
    assign tx_right   = tx_lrpol ? lr_fall : lr_rise;
    assign tx_pop     = tx_active && tx_left && !tx_data_l_empty && !tx_data_r_empty;
    assign tx_fill_ok = tx_data_fill && !tx_data_l_full && !tx_data_r_full;
    assign new_l      = tx_pop ? tl_head : 32'd0;
    assign new_r      = tx_pop ? tr_head : 32'd0;
    assign tx         = tx_q;

    // Serializer: a slot edge that coincides with a transmit edge drives period 0 immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_started <= 1'b0; tx_in_right <= 1'b0; tx_q <= 1'b0;
            tx_pidx <= 6'd0; tx_word_l <= 32'd0; tx_word_r <= 32'd0;
        end else if (!tx_active) begin
            tx_started <= 1'b0; tx_in_right <= 1'b0; tx_q <= 1'b0;
            tx_pidx <= 6'd0; tx_word_l <= 32'd0; tx_word_r <= 32'd0;
        end else if (tx_left) begin
            tx_started  <= 1'b1;
            tx_in_right <= 1'b0;
            tx_word_l   <= new_l;
            tx_word_r   <= new_r;
            if (tx_ev) tx_q <= slot_bit(new_l, 6'd0, msb_delay_bits);
            tx_pidx <= tx_ev ? 6'd1 : 6'd0;
        end else if (tx_right && tx_started) begin
            tx_in_right <= 1'b1;
            if (tx_ev) tx_q <= slot_bit(tx_word_r, 6'd0, msb_delay_bits);
            tx_pidx <= tx_ev ? 6'd1 : 6'd0;
        end else if (tx_ev && tx_started) begin
            tx_q    <= slot_bit(tx_in_right ? tx_word_r : tx_word_l, tx_pidx, msb_delay_bits);
            tx_pidx <= (tx_pidx == 6'd63) ? tx_pidx : tx_pidx + 6'd1;
        end
    end

    // Receive side
    logic        rx_active, rx_ev, rx_left, rx_right, rx_push, rx_drain_ok;
    logic        rx_started, rx_in_right;
    logic [5:0]  rx_pidx;
    logic [31:0] rx_cur, rx_l_hold, rx_word;

    assign rx_active   = enable && enable_rx;
    assign rx_ev       = rx_bpol ? b_rise : b_fall;
    assign rx_left     = rx_lrpol ? lr_rise : lr_fall;
    assign rx_right    = rx_lrpol ? lr_fall : lr_rise;
    assign rx_word     = (rx_ev && rx_started) ? slot_set(rx_cur, rx_pidx, msb_delay_bits, rx_bit) : rx_cur;
    assign rx_push     = rx_active && rx_left && rx_started && rx_in_right && !rx_data_l_full && !rx_data_r_full;
    assign rx_drain_ok = rx_data_drain && !rx_data_l_empty && !rx_data_r_empty;

    // Deserializer: a capture edge on a slot boundary still belongs to the slot that is ending
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_started <= 1'b0; rx_in_right <= 1'b0; rx_pidx <= 6'd0;
            rx_cur <= 32'd0; rx_l_hold <= 32'd0;
        end else if (!rx_active) begin
            rx_started <= 1'b0; rx_in_right <= 1'b0; rx_pidx <= 6'd0;
            rx_cur <= 32'd0; rx_l_hold <= 32'd0;
        end else if (rx_left) begin
            rx_started  <= 1'b1;
            rx_in_right <= 1'b0;
            rx_cur      <= 32'd0;
            rx_pidx     <= 6'd0;
        end else if (rx_right && rx_started) begin
            rx_l_hold   <= rx_word;
            rx_in_right <= 1'b1;
            rx_cur      <= 32'd0;
            rx_pidx     <= 6'd0;
        end else if (rx_ev && rx_started) begin
            rx_cur  <= rx_word;
            rx_pidx <= (rx_pidx == 6'd63) ? rx_pidx : rx_pidx + 6'd1;
        end
    end

    iis_fifo u_tx_l (.clk(clk), .rstn(rstn), .clear(tx_data_clear), .push(tx_fill_ok), .pop(tx_pop),
                     .depth(tx_data_depth), .wdata(tx_data_l), .rdata(tl_head), .count(tx_data_l_count),
                     .full(tx_data_l_full), .empty(tx_data_l_empty));
    iis_fifo u_tx_r (.clk(clk), .rstn(rstn), .clear(tx_data_clear), .push(tx_fill_ok), .pop(tx_pop),
                     .depth(tx_data_depth), .wdata(tx_data_r), .rdata(tr_head), .count(tx_data_r_count),
                     .full(tx_data_r_full), .empty(tx_data_r_empty));
    iis_fifo u_rx_l (.clk(clk), .rstn(rstn), .clear(rx_data_clear), .push(rx_push), .pop(rx_drain_ok),
                     .depth(rx_data_depth), .wdata(rx_l_hold), .rdata(rx_data_l), .count(rx_data_l_count),
                     .full(rx_data_l_full), .empty(rx_data_l_empty));
    iis_fifo u_rx_r (.clk(clk), .rstn(rstn), .clear(rx_data_clear), .push(rx_push), .pop(rx_drain_ok),
                     .depth(rx_data_depth), .wdata(rx_word), .rdata(rx_data_r), .count(rx_data_r_count),
                     .full(rx_data_r_full), .empty(rx_data_r_empty));
endmodule

// File: tb/tb_iis_controller.sv
// tb/tb_iis_controller.sv - self-checking bench for iis_controller (master/slave loopback pair)

module tb_iis_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, enable;
    logic [31:0] bdiv, lrbdiv;
    logic [3:0]  delay;
    logic [2:0]  depth;

    logic        a_bclk_o, a_lrclk_o, a_tx, b_bclk_o, b_lrclk_o, b_tx;
    logic [31:0] a_tx_l, a_tx_r, b_tx_l, b_tx_r;
    logic        a_fill, a_tclr, b_fill, b_tclr, a_drain, a_rclr, b_drain, b_rclr;
    logic        a_tlf, a_tle, a_trf, a_tre, b_tlf, b_tle, b_trf, b_tre;
    logic [3:0]  a_tlc, a_trc, b_tlc, b_trc, a_rlc, a_rrc, b_rlc, b_rrc;
    logic [31:0] a_rx_l, a_rx_r, b_rx_l, b_rx_r;
    logic        a_rlf, a_rle, a_rrf, a_rre, b_rlf, b_rle, b_rrf, b_rre;

    iis_controller u_a (
        .clk(clk), .rstn(rstn), .test_se(1'b0), .enable(enable), .enable_master(1'b1),
        .bdiv(bdiv), .lrbdiv(lrbdiv), .msb_delay_bits(delay), .bclk_i(1'b0), .lrclk_i(1'b0),
        .bclk_o(a_bclk_o), .lrclk_o(a_lrclk_o), .enable_tx(1'b1), .tx_bpol(1'b0), .tx_lrpol(1'b1),
        .tx_data_l(a_tx_l), .tx_data_r(a_tx_r), .tx_data_fill(a_fill), .tx_data_clear(a_tclr),
        .tx_data_depth(depth), .tx_data_l_full(a_tlf), .tx_data_l_empty(a_tle), .tx_data_r_full(a_trf),
        .tx_data_r_empty(a_tre), .tx_data_l_count(a_tlc), .tx_data_r_count(a_trc), .tx(a_tx),
        .enable_rx(1'b1), .rx_bpol(1'b1), .rx_lrpol(1'b1), .rx(b_tx), .rx_data_l(a_rx_l), .rx_data_r(a_rx_r),
        .rx_data_drain(a_drain), .rx_data_clear(a_rclr), .rx_data_depth(depth), .rx_data_l_full(a_rlf),
        .rx_data_l_empty(a_rle), .rx_data_r_full(a_rrf), .rx_data_r_empty(a_rre),
        .rx_data_l_count(a_rlc), .rx_data_r_count(a_rrc));

    iis_controller u_b (
        .clk(clk), .rstn(rstn), .test_se(1'b0), .enable(enable), .enable_master(1'b0),
        .bdiv(bdiv), .lrbdiv(lrbdiv), .msb_delay_bits(delay), .bclk_i(a_bclk_o), .lrclk_i(a_lrclk_o),
        .bclk_o(b_bclk_o), .lrclk_o(b_lrclk_o), .enable_tx(1'b1), .tx_bpol(1'b0), .tx_lrpol(1'b1),
        .tx_data_l(b_tx_l), .tx_data_r(b_tx_r), .tx_data_fill(b_fill), .tx_data_clear(b_tclr),
        .tx_data_depth(depth), .tx_data_l_full(b_tlf), .tx_data_l_empty(b_tle), .tx_data_r_full(b_trf),
        .tx_data_r_empty(b_tre), .tx_data_l_count(b_tlc), .tx_data_r_count(b_trc), .tx(b_tx),
        .enable_rx(1'b1), .rx_bpol(1'b1), .rx_lrpol(1'b1), .rx(a_tx), .rx_data_l(b_rx_l), .rx_data_r(b_rx_r),
        .rx_data_drain(b_drain), .rx_data_clear(b_rclr), .rx_data_depth(depth), .rx_data_l_full(b_rlf),
        .rx_data_l_empty(b_rle), .rx_data_r_full(b_rrf), .rx_data_r_empty(b_rre),
        .rx_data_l_count(b_rlc), .rx_data_r_count(b_rrc));

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Only the bits whose period delay+k still lies inside the slot survive the wire
    function automatic logic [31:0] on_wire(input logic [31:0] w, input int d, input int slot);
        int nb;
        nb = slot - d;
        if (nb >= 32) return w;
        if (nb <= 0) return 32'd0;
        return (w >> (32 - nb)) << (32 - nb);
    endfunction

    typedef struct {
        logic [2:0] depth;
        logic       fill;
        logic       clear;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
    } fvec_t;
    fvec_t vecs[$];

    task automatic do_reset();
        rstn = 1'b0; enable = 1'b0;
        a_fill = 0; a_tclr = 0; a_drain = 0; a_rclr = 0;
        b_fill = 0; b_tclr = 0; b_drain = 0; b_rclr = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_pair(input logic to_b, input logic [31:0] l, input logic [31:0] r);
        if (to_b) begin b_tx_l = l; b_tx_r = r; b_fill = 1'b1; end
        else begin a_tx_l = l; a_tx_r = r; a_fill = 1'b1; end
        @(negedge clk);
        a_fill = 1'b0; b_fill = 1'b0;
    endtask

    task automatic run_loopback(input int d, input int npairs, input logic fixed_a);
        logic [31:0] sa_l[5], sa_r[5], sb_l[5], sb_r[5];
        do_reset();
        delay = d[3:0]; depth = 3'd5; bdiv = 32'd13; lrbdiv = 32'd32;
        for (int i = 0; i < 5; i++) begin
            sa_l[i] = 32'd0; sa_r[i] = 32'd0; sb_l[i] = 32'd0; sb_r[i] = 32'd0;
        end
        for (int i = 0; i < npairs; i++) begin
            if (fixed_a) begin
                sa_l[i] = (i % 2 == 0) ? 32'hB77BEFDF : 32'h48841020;
                sa_r[i] = (i % 2 == 0) ? 32'hFBF7DEED : 32'h04082112;
            end else begin
                sa_l[i] = $urandom; sa_r[i] = $urandom;
            end
            sb_l[i] = $urandom; sb_r[i] = $urandom;
            fill_pair(1'b0, sa_l[i], sa_r[i]);
            fill_pair(1'b1, sb_l[i], sb_r[i]);
        end
        enable = 1'b1;
        repeat (416 + 8 * 832 + 50) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("b_rx_count_overflow_hold", {28'd0, b_rlc}, 32'd5);
        check("b_rx_full", {31'd0, b_rlf}, 32'd1);
        check("a_rx_count_overflow_hold", {28'd0, a_rrc}, 32'd5);
        check("a_tx_drained_by_frames", {28'd0, a_tlc}, 32'd0);
        for (int f = 0; f < 5; f++) begin
            check($sformatf("b_rx_l[%0d]", f), b_rx_l, on_wire(sa_l[f], d, 32));
            check($sformatf("b_rx_r[%0d]", f), b_rx_r, on_wire(sa_r[f], d, 32));
            check($sformatf("a_rx_l[%0d]", f), a_rx_l, on_wire(sb_l[f], d, 32));
            check($sformatf("a_rx_r[%0d]", f), a_rx_r, on_wire(sb_r[f], d, 32));
            a_drain = 1'b1; b_drain = 1'b1;
            @(negedge clk);
            a_drain = 1'b0; b_drain = 1'b0;
        end
        check("b_rx_empty_after_drain", {31'd0, b_rle}, 32'd1);
        check("a_rx_count_after_drain", {28'd0, a_rlc}, 32'd0);
    endtask

    initial begin
        int n, h, l, p;
        a_tx_l = 0; a_tx_r = 0; b_tx_l = 0; b_tx_r = 0;
        bdiv = 32'd13; lrbdiv = 32'd32; delay = 4'd1; depth = 3'd5;

        // FIFO limit vectors on A's transmit FIFO (held idle, so nothing pops)
        for (int i = 0; i < 5; i++) vecs.push_back('{3'd5, 1'b1, 1'b0, 4'(i + 1), (i == 4), 1'b0});
        vecs.push_back('{3'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0});
        vecs.push_back('{3'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1});
        for (int i = 0; i < 8; i++) vecs.push_back('{3'd0, 1'b1, 1'b0, 4'(i + 1), (i == 7), 1'b0});
        vecs.push_back('{3'd0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0});
        vecs.push_back('{3'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1});

        rstn = 1'b0; enable = 1'b0;
        a_fill = 0; a_tclr = 0; a_drain = 0; a_rclr = 0;
        b_fill = 0; b_tclr = 0; b_drain = 0; b_rclr = 0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, a_tx}, 32'd0);
        check("reset_bclk_o", {31'd0, a_bclk_o}, 32'd0);
        check("reset_lrclk_o", {31'd0, a_lrclk_o}, 32'd0);
        check("reset_counts", {16'd0, a_tlc, a_trc, a_rlc, a_rrc}, 32'd0);
        check("reset_empty", {28'd0, a_tle, a_tre, a_rle, a_rre}, 32'hF);
        check("reset_full", {28'd0, a_tlf, a_trf, a_rlf, a_rrf}, 32'h0);
        check("reset_rx_heads", a_rx_l | a_rx_r, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            depth = vecs[i].depth; a_fill = vecs[i].fill; a_tclr = vecs[i].clear;
            a_tx_l = $urandom; a_tx_r = $urandom;
            @(negedge clk);
            a_fill = 1'b0; a_tclr = 1'b0;
            check($sformatf("fifo_vec[%0d]", i), {22'd0, a_tlc, a_trc, a_tlf, a_trf, a_tle, a_tre},
                  {22'd0, vecs[i].cnt, vecs[i].cnt, vecs[i].full, vecs[i].full, vecs[i].empty, vecs[i].empty});
        end

        a_drain = 1'b1;
        @(negedge clk);
        a_drain = 1'b0;
        check("drain_on_empty", {27'd0, a_rle, a_rlc}, {27'd0, 1'b1, 4'd0});

        // Master clock generation
        depth = 3'd5; enable = 1'b1;
        n = 0;
        while (a_bclk_o !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (a_bclk_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        h = 0; while (a_bclk_o === 1'b1 && h < 100) begin @(negedge clk); h++; end
        l = 0; while (a_bclk_o === 1'b0 && l < 100) begin @(negedge clk); l++; end
        check("bclk_high_cycles", h, 32'd7);
        check("bclk_low_cycles", l, 32'd6);
        n = 0;
        while (a_lrclk_o !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        while (a_lrclk_o !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        p = 0; while (a_lrclk_o === 1'b1 && p < 2000) begin @(negedge clk); p++; end
        h = p;
        while (a_lrclk_o === 1'b0 && p < 2000) begin @(negedge clk); p++; end
        check("lrclk_high_cycles", h, 32'd416);
        check("lrclk_period", p, 32'd832);
        check("slave_bclk_o_low", {30'd0, b_bclk_o, b_lrclk_o}, 32'd0);
        enable = 1'b0;

        // Standard I2S loopback with underflow and overflow, then left-justified
        run_loopback(1, 4, 1'b1);
        run_loopback(0, 3, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
